// File: rtl/input_feeder_pkg.sv
// Shared types and sizes for the input feeder: FSM state encoding and the
// controller-facing offset width.
package input_feeder_pkg;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    LAUNCH  = 2'd1,
    SERVE   = 2'd2,
    RELEASE = 2'd3
  } state_e;

  localparam int OFFSET_W       = 3;
  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 1 << OFFSET_W;

endpackage

// File: rtl/input_feeder_bank.sv
// DEPTH x DATA_W register file holding one input vector; one write port and a
// registered read port whose output holds between reads.
module input_feeder_bank #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Only the read register is reset; stale vector contents are never exposed
  // because the FSM refuses reads until a full vector has been written.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/input_feeder.sv
// Collects a DEPTH-word vector from a valid/ready stream and serves it to the
// NN controller. Define INPUT_FEEDER_PINGPONG_EN for a second bank that fills
// while the other is being served.
module input_feeder
  import input_feeder_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  output logic                in_ready,
  output logic                start,
  input  logic                read,
  input  logic [OFFSET_W-1:0] offset,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  input  logic                nn_ready,
  output logic                done
);

`ifdef INPUT_FEEDER_PINGPONG_EN
  localparam int NBANK = 2;
`else
  localparam int NBANK = 1;
`endif

  state_e              state_q;
  logic [OFFSET_W-1:0] cnt_q;
  logic                in_ready_q;
  logic                start_q;
  logic                done_q;
  logic                rd_valid_q;

  logic xfer;
  logic last_word;
  logic serve_rd;

  assign xfer      = in_valid & in_ready_q;
  assign last_word = xfer & (cnt_q == OFFSET_W'(DEPTH - 1));
  assign serve_rd  = read & (state_q == SERVE);

  logic [DATA_W-1:0] bank_rdata [NBANK];

`ifdef INPUT_FEEDER_PINGPONG_EN
  logic       fill_ptr_q;
  logic       rd_sel_q;
  logic [1:0] full_q;
  logic       full_now;

  // The fill bank counts as full in the same cycle its last word arrives.
  assign full_now = full_q[fill_ptr_q] | last_word;
  assign rd_data  = bank_rdata[rd_sel_q];
`else
  assign rd_data  = bank_rdata[0];
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NBANK; gi++) begin : g_bank
      logic bank_we;
      logic bank_re;
`ifdef INPUT_FEEDER_PINGPONG_EN
      assign bank_we = xfer & (fill_ptr_q == 1'(gi));
      assign bank_re = serve_rd & (fill_ptr_q != 1'(gi));
`else
      assign bank_we = xfer;
      assign bank_re = serve_rd;
`endif
      input_feeder_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
      ) u_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (bank_we),
        .waddr (cnt_q),
        .wdata (in_data),
        .re    (bank_re),
        .raddr (offset),
        .rdata (bank_rdata[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
`ifdef INPUT_FEEDER_PINGPONG_EN
      fill_ptr_q <= 1'b0;
      rd_sel_q   <= 1'b0;
      full_q     <= 2'b00;
`endif
    end else begin
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= serve_rd;
      if (xfer) begin
        cnt_q <= cnt_q + OFFSET_W'(1);
      end
`ifdef INPUT_FEEDER_PINGPONG_EN
      if (last_word) begin
        full_q[fill_ptr_q] <= 1'b1;
      end
      // Remember which bank produced rd_data so it holds across a swap.
      if (serve_rd) begin
        rd_sel_q <= ~fill_ptr_q;
      end
      in_ready_q <= ~full_now;
      case (state_q)
        FILL: begin
          if (full_now) begin
            fill_ptr_q <= ~fill_ptr_q;
            in_ready_q <= 1'b1;
            start_q    <= 1'b1;
            state_q    <= LAUNCH;
          end
        end
        LAUNCH: state_q <= SERVE;
        SERVE: begin
          if (nn_ready) begin
            done_q  <= 1'b1;
            state_q <= RELEASE;
          end
        end
        RELEASE: begin
          full_q[~fill_ptr_q] <= 1'b0;
          if (full_now) begin
            fill_ptr_q <= ~fill_ptr_q;
            in_ready_q <= 1'b1;
            start_q    <= 1'b1;
            state_q    <= LAUNCH;
          end else begin
            state_q <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
`else
      case (state_q)
        FILL: begin
          in_ready_q <= 1'b1;
          if (last_word) begin
            in_ready_q <= 1'b0;
            start_q    <= 1'b1;
            state_q    <= LAUNCH;
          end
        end
        LAUNCH: state_q <= SERVE;
        SERVE: begin
          if (nn_ready) begin
            done_q  <= 1'b1;
            state_q <= RELEASE;
          end
        end
        RELEASE: begin
          in_ready_q <= 1'b1;
          state_q    <= FILL;
        end
        default: state_q <= FILL;
      endcase
`endif
    end
  end

  assign in_ready = in_ready_q;
  assign start    = start_q;
  assign done     = done_q;
  assign rd_valid = rd_valid_q;

endmodule
